timed_write_queue: RTL and testbench

//   Receiving end of a delayed-assignment interface: accepts (data, delay)

---
 rtl/timed_write_queue.sv | 94 +++++++++
 tb/tb_timed_write_queue.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/timed_write_queue.sv
// Delayed-write release queue: each accepted word waits in a slot for its
// programmed number of cycles, then is offered on a valid/ready port.
module timed_write_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int DLY_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   input  logic [DLY_W-1:0]           in_delay,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] pending
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0] slot_vld;
   logic [WIDTH-1:0] slot_data [DEPTH];
   logic [DLY_W-1:0] slot_cnt  [DEPTH];
   logic             ready_q;

   logic             free_hit;
   logic [IDX_W-1:0] free_idx;
   logic             exp_hit;
   logic [IDX_W-1:0] exp_idx;
   logic [CNT_W-1:0] pend_cnt;
   logic             accept;
   logic             pop;

   // Scan from the top down so the lowest index wins in both searches.
   always_comb begin
      free_hit = 1'b0;
      free_idx = '0;
      exp_hit  = 1'b0;
      exp_idx  = '0;
      pend_cnt = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!slot_vld[i]) begin
            free_hit = 1'b1;
            free_idx = IDX_W'(i);
         end
         if (slot_vld[i] && (slot_cnt[i] == '0)) begin
            exp_hit = 1'b1;
            exp_idx = IDX_W'(i);
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         pend_cnt = pend_cnt + CNT_W'(slot_vld[i]);
      end
   end

   // ready_q keeps in_ready low through reset and the first cycle after it.
   assign in_ready  = ready_q & free_hit;
   assign out_valid = exp_hit;
   assign out_data  = slot_data[exp_idx];
   assign pending   = pend_cnt;

   assign accept = in_valid & in_ready;
   assign pop    = exp_hit & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q  <= 1'b0;
         slot_vld <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            slot_data[i] <= '0;
            slot_cnt[i]  <= '0;
         end
      end else begin
         ready_q <= 1'b1;
         // An accepted slot is free before the edge and a popped slot is
         // occupied, so the two never target the same index.
         for (int i = 0; i < DEPTH; i++) begin
            if (pop && (exp_idx == IDX_W'(i))) begin
               slot_vld[i] <= 1'b0;
            end else if (slot_vld[i] && (slot_cnt[i] != '0)) begin
               slot_cnt[i] <= slot_cnt[i] - 1'b1;
            end
            if (accept && (free_idx == IDX_W'(i))) begin
               slot_vld[i]  <= 1'b1;
               slot_data[i] <= in_data;
               slot_cnt[i]  <= in_delay;
            end
         end
      end
   end

endmodule

// File: tb/tb_timed_write_queue.sv
// Directed bench for timed_write_queue: a linear sequence of steps with
// hand-computed expectations checked by immediate assertions.
module tb_timed_write_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [7:0]  in_delay;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [2:0]  pending;

   int checks = 0;
   int errors = 0;
   logic seen;

   timed_write_queue #(.WIDTH(32), .DEPTH(4), .DLY_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_delay  (in_delay),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs are driven and outputs sampled 1 after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic [7:0] dly);
      in_valid = 1'b1;
      in_data  = d;
      in_delay = dly;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_delay = '0; out_ready = 1'b1;
      step(); step();
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_pending", 32'(pending), 0);
      rst = 1'b0;
      step();
      check("post_rst_out_valid", 32'(out_valid), 0);
      check("post_rst_in_ready", 32'(in_ready), 1);

      // 1: delay 0 is presented in the very next cycle only
      push(32'h11, 8'd0);
      step();
      in_valid = 1'b0;
      check("t1_valid", 32'(out_valid), 1);
      check("t1_data", out_data, 32'h11);
      check("t1_pend1", 32'(pending), 1);
      step();
      check("t1_gone", 32'(out_valid), 0);
      check("t1_pend0", 32'(pending), 0);

      // 2: delay 55 -> silent for 55 cycles, presented in cycle 56
      push(32'h23, 8'd55);
      step();
      in_valid = 1'b0;
      seen = 1'b0;
      for (int k = 1; k <= 55; k++) begin
         if (out_valid) seen = 1'b1;
         step();
      end
      check("t2_early", 32'(seen), 0);
      check("t2_valid", 32'(out_valid), 1);
      check("t2_data", out_data, 32'h23);
      step();
      check("t2_pend0", 32'(pending), 0);

      // 3: fill with 10,3,3,7 on consecutive edges E0..E3; 5th held.
      // slot0 and slot3 both expire after E10; slot0 wins on index.
      push(32'hA0, 8'd10); step();
      push(32'hA1, 8'd3);  step();
      push(32'hA2, 8'd3);  step();
      push(32'hA3, 8'd7);  step();
      check("t3_full_pend", 32'(pending), 4);
      check("t3_full_ready", 32'(in_ready), 0);
      push(32'hA4, 8'd20);
      step();
      check("t3_e4_ready", 32'(in_ready), 0);
      check("t3_e4_data", out_data, 32'hA1);
      step();
      check("t3_e5_data", out_data, 32'hA2);
      check("t3_e5_ready", 32'(in_ready), 1);
      check("t3_e5_pend", 32'(pending), 3);
      step();
      in_valid = 1'b0;
      check("t3_e6_pend", 32'(pending), 3);
      check("t3_e6_valid", 32'(out_valid), 0);
      step(); step(); step();
      check("t3_e9_valid", 32'(out_valid), 0);
      step();
      check("t3_e10_data", out_data, 32'hA0);
      step();
      check("t3_e11_data", out_data, 32'hA3);
      check("t3_e11_pend", 32'(pending), 2);
      step();
      check("t3_e12_valid", 32'(out_valid), 0);
      check("t3_e12_pend", 32'(pending), 1);
      repeat (13) step();
      check("t3_e25_valid", 32'(out_valid), 0);
      step();
      check("t3_e26_data", out_data, 32'hA4);
      step();
      check("t3_drain", 32'(pending), 0);

      // 4: delay-3 word held under backpressure for 5 cycles
      out_ready = 1'b0;
      push(32'hB4, 8'd3);
      step();
      in_valid = 1'b0;
      step(); step();
      check("t4_early", 32'(out_valid), 0);
      step();
      check("t4_valid", 32'(out_valid), 1);
      check("t4_data", out_data, 32'hB4);
      seen = 1'b0;
      repeat (4) begin
         step();
         if (!out_valid || out_data !== 32'hB4) seen = 1'b1;
      end
      check("t4_held", 32'(seen), 0);
      out_ready = 1'b1;
      step();
      check("t4_popped", 32'(out_valid), 0);
      check("t4_pend0", 32'(pending), 0);

      // 5: reset mid-countdown discards everything
      push(32'hD0, 8'd10); step();
      push(32'hD1, 8'd10); step();
      push(32'hD2, 8'd10); step();
      in_valid = 1'b0;
      step(); step();
      check("t5_pend3", 32'(pending), 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t5_rst_pend", 32'(pending), 0);
      check("t5_rst_ready", 32'(in_ready), 0);
      seen = 1'b0;
      repeat (15) begin
         if (out_valid) seen = 1'b1;
         step();
      end
      check("t5_no_valid", 32'(seen), 0);
      check("t5_pend_end", 32'(pending), 0);

      // 6: full queue, pop and request in the same cycle
      out_ready = 1'b0;
      push(32'hC0, 8'd0); step();
      push(32'hC1, 8'd5); step();
      push(32'hC2, 8'd5); step();
      push(32'hC3, 8'd5); step();
      push(32'hC4, 8'd0);
      check("t6_full_ready", 32'(in_ready), 0);
      check("t6_full_data", out_data, 32'hC0);
      out_ready = 1'b1;
      step();
      check("t6_e4_pend", 32'(pending), 3);
      check("t6_e4_ready", 32'(in_ready), 1);
      check("t6_e4_valid", 32'(out_valid), 0);
      step();
      in_valid = 1'b0;
      check("t6_e5_pend", 32'(pending), 4);
      check("t6_e5_data", out_data, 32'hC4);
      step();
      check("t6_e6_data", out_data, 32'hC1);
      check("t6_e6_pend", 32'(pending), 3);
      step();
      check("t6_e7_data", out_data, 32'hC2);
      step();
      check("t6_e8_data", out_data, 32'hC3);
      step();
      check("t6_e9_pend", 32'(pending), 0);

      // maximum delay 255 -> presented in cycle 256
      push(32'hFF, 8'd255);
      step();
      in_valid = 1'b0;
      seen = 1'b0;
      repeat (255) begin
         if (out_valid) seen = 1'b1;
         step();
      end
      check("max_early", 32'(seen), 0);
      check("max_data", out_data, 32'hFF);
      check("max_valid", 32'(out_valid), 1);
      step();
      check("max_pend0", 32'(pending), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
